channel_tone_generator: RTL and testbench

Downstream consumer of a channel note sequencer. It turns the sequencer's 32-bit phase delta and 8-bit top/duty value into an 8-bit unsigned audio sample stream.
- Runs a phase accumulator advanced on each sample tick.
- Shapes the accumulator's upper byte into square, triangle, sawtooth or LFSR noise.
- Applies a new pitch only at the next phase wrap, so note changes are glitch-free.
- Feeds the channel mixer one sample per tick.

---
 rtl/channel_tone_if.sv | 31 +++
 rtl/channel_tone_generator.sv | 142 ++++++++++++++
 tb/tb_channel_tone_generator.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_tone_if.sv
// Sequencer-to-tone-generator bus: pitch/duty/waveform in, sample stream out.
// With CH_VOLUME_EN defined the bus also carries a 4-bit volume.
`timescale 1ns/1ps
interface channel_tone_if;
   logic        i_tick_stb;
   logic [31:0] i_phase_delta;
   logic [7:0]  i_top;
   logic        i_top_valid;
   logic [1:0]  i_waveform;
`ifdef CH_VOLUME_EN
   logic [3:0]  i_volume;
`endif
   logic [7:0]  o_sample;
   logic        o_sample_valid;

   modport master (
`ifdef CH_VOLUME_EN
      output i_volume,
`endif
      output i_tick_stb, i_phase_delta, i_top, i_top_valid, i_waveform,
      input  o_sample, o_sample_valid
   );

   modport slave (
`ifdef CH_VOLUME_EN
      input  i_volume,
`endif
      input  i_tick_stb, i_phase_delta, i_top, i_top_valid, i_waveform,
      output o_sample, o_sample_valid
   );
endinterface

// File: rtl/channel_tone_generator.sv
// Phase-accumulator tone source: square, triangle, sawtooth or LFSR noise, one sample per tick.
// Optional macro CH_VOLUME_EN adds a volume-scaling stage (latency 3 instead of 2).
`timescale 1ns/1ps
module channel_tone_generator #(
   parameter logic [14:0] LFSR_SEED     = 15'h7FFF,
   parameter logic [7:0]  SILENCE_LEVEL = 8'h80
) (
   input  logic           i_clk,
   input  logic           i_rst,
   channel_tone_if.slave  bus
);

   typedef enum logic [1:0] {
      WF_SQUARE   = 2'd0,
      WF_TRIANGLE = 2'd1,
      WF_SAW      = 2'd2,
      WF_NOISE    = 2'd3
   } waveform_e;

   logic [31:0] r_phase;
   logic [31:0] r_active_delta;
   logic [31:0] r_pending_delta;
   logic [7:0]  r_top;
   logic [14:0] r_lfsr;
   logic        r_s1_valid;
   logic [7:0]  r_sample;
   logic        r_sample_valid;

   logic [32:0] phase_sum;
   logic [7:0]  p;
   logic [7:0]  tri_ramp;
   logic [7:0]  shaped;
   waveform_e   wave;

   assign phase_sum = {1'b0, r_phase} + {1'b0, r_active_delta};
   assign p         = r_phase[31:24];
   assign tri_ramp  = {p[6:0], 1'b0};
   assign wave      = waveform_e'(bus.i_waveform);

   // Stage 1: accumulator, pitch adoption and noise LFSR.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase         <= '0;
         r_active_delta  <= '0;
         r_pending_delta <= '0;
         r_top           <= 8'hFF;
         r_lfsr          <= LFSR_SEED;
         r_s1_valid      <= 1'b0;
      end else begin
         r_pending_delta <= bus.i_phase_delta;
         r_s1_valid      <= bus.i_tick_stb;
         if (bus.i_top_valid) begin
            r_top <= bus.i_top;
         end
         // A note starting from rest begins at phase 0; otherwise pitch changes wait for a wrap.
         if (r_active_delta == '0) begin
            r_active_delta <= r_pending_delta;
            r_phase        <= '0;
         end else if (bus.i_tick_stb) begin
            r_phase <= phase_sum[31:0];
            if (phase_sum[32]) begin
               r_active_delta <= r_pending_delta;
               r_lfsr         <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
            end
         end
      end
   end

   // Stage 2 waveform shaping from the accumulator's upper byte.
   always_comb begin
      // NOTE: default assigned first so no path leaves shaped unassigned (no latch).
      shaped = SILENCE_LEVEL;
      if (r_active_delta != '0) begin
         unique case (wave)
            WF_SQUARE:   shaped = (p <= {1'b0, r_top[7:1]}) ? 8'hFF : 8'h00;
            WF_TRIANGLE: shaped = p[7] ? ~tri_ramp : tri_ramp;
            WF_SAW:      shaped = p;
            WF_NOISE:    shaped = r_lfsr[0] ? 8'hFF : 8'h00;
         endcase
      end
   end

`ifdef CH_VOLUME_EN
   logic [7:0]         r_s2_sample;
   logic               r_s2_valid;
   logic signed [8:0]  vol_diff;
   logic signed [13:0] vol_prod;
   logic signed [13:0] vol_scaled;
   logic signed [14:0] vol_level;
   logic [7:0]         vol_sample;

   assign vol_diff   = $signed({1'b0, r_s2_sample}) - $signed({1'b0, SILENCE_LEVEL});
   assign vol_prod   = vol_diff * $signed({1'b0, bus.i_volume});
   assign vol_scaled = vol_prod >>> 4;
   assign vol_level  = {vol_scaled[13], vol_scaled} + $signed({7'd0, SILENCE_LEVEL});

   // Clamp to the unsigned 8-bit sample range.
   always_comb begin
      vol_sample = vol_level[7:0];
      if (vol_level[14]) begin
         vol_sample = 8'h00;
      end else if (|vol_level[13:8]) begin
         vol_sample = 8'hFF;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s2_sample    <= SILENCE_LEVEL;
         r_s2_valid     <= 1'b0;
         r_sample       <= SILENCE_LEVEL;
         r_sample_valid <= 1'b0;
      end else begin
         r_s2_valid     <= r_s1_valid;
         r_sample_valid <= r_s2_valid;
         if (r_s1_valid) begin
            r_s2_sample <= shaped;
         end
         if (r_s2_valid) begin
            r_sample <= vol_sample;
         end
      end
   end
`else
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sample       <= SILENCE_LEVEL;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_sample <= shaped;
         end
      end
   end
`endif

   assign bus.o_sample       = r_sample;
   assign bus.o_sample_valid = r_sample_valid;

endmodule

// File: tb/tb_channel_tone_generator.sv
// Self-checking bench for channel_tone_generator: randomized ticks against a tick-level reference model.
// Honours CH_VOLUME_EN (volume stage, latency 3) when defined.
`timescale 1ns/1ps
module tb_channel_tone_generator;

`ifdef CH_VOLUME_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   channel_tone_if bus ();

   channel_tone_generator dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state, advanced once per tick.
   logic [31:0] m_phase;
   logic [31:0] m_delta;
   logic [31:0] m_req;
   logic [7:0]  m_top;
   logic [14:0] m_lfsr;
   logic [1:0]  m_wave;
   int          m_vol;
   logic [7:0]  m_last;
   logic [7:0]  exp_q[$];

   function automatic logic [7:0] wave_value(logic [1:0] wf, logic [7:0] pb, logic [7:0] top,
                                             logic noise_bit, logic resting);
      int pi;
      pi = int'(pb);
      if (resting) return 8'h80;
      case (wf)
         2'd0:    return (pi <= int'(top) / 2) ? 8'hFF : 8'h00;
         2'd1:    return (pi < 128) ? 8'(2 * pi) : 8'(255 - 2 * (pi - 128));
         2'd2:    return pb;
         default: return noise_bit ? 8'hFF : 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] vol_apply(logic [7:0] s, int vol);
`ifdef CH_VOLUME_EN
      int v;
      v = ((int'(s) - 128) * vol) >>> 4;
      v = v + 128;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      return 8'(v);
`else
      return (vol >= 0) ? s : s;
`endif
   endfunction

   task automatic model_tick();
      longint sum;
      sum = longint'(m_phase) + longint'(m_delta);
      m_phase = sum[31:0];
      if (sum[32]) begin
         m_lfsr  = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
         m_delta = m_req;
         if (m_delta == 0) m_phase = 0;
      end
      exp_q.push_back(vol_apply(wave_value(m_wave, m_phase[31:24], m_top, m_lfsr[0], m_delta == 0), m_vol));
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_delta = m_req;
      m_lfsr  = 15'h7FFF;
      m_top   = 8'hFF;
      m_last  = 8'h80;
      exp_q.delete();
   endtask

   // Drive k back-to-back ticks; check valid timing, sample values and hold behaviour.
   task automatic run_ticks(string name, int k);
      logic exp_v;
      logic [7:0] exp_s;
      for (int j = 0; j < k; j++) model_tick();
      for (int i = 0; i <= k + LAT; i++) begin
         @(negedge clk);
         exp_v = (i >= LAT) && (i < k + LAT);
         tests++;
         if (bus.o_sample_valid !== exp_v) begin
            fails++;
            $display("FAIL %s valid cyc=%0d got=%b want=%b", name, i, bus.o_sample_valid, exp_v);
         end
         exp_s = m_last;
         if (exp_v) begin
            exp_s  = exp_q.pop_front();
            m_last = exp_s;
         end
         tests++;
         if (bus.o_sample !== exp_s) begin
            fails++;
            $display("FAIL %s sample cyc=%0d got=%h want=%h", name, i, bus.o_sample, exp_s);
         end
         bus.i_tick_stb = (i < k);
      end
   endtask

   task automatic set_delta(logic [31:0] d);
      @(negedge clk);
      bus.i_phase_delta = d;
      m_req = d;
      if (m_delta == 0) begin
         m_delta = d;
         m_phase = 0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic set_top(logic [7:0] t);
      @(negedge clk);
      bus.i_top = t;
      bus.i_top_valid = 1'b1;
      @(negedge clk);
      bus.i_top_valid = 1'b0;
      m_top = t;
   endtask

   task automatic set_wave(logic [1:0] w);
      @(negedge clk);
      bus.i_waveform = w;
      m_wave = w;
   endtask

   task automatic do_reset();
      set_delta(32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (bus.o_sample !== 8'h80 || bus.o_sample_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset got=%h/%b want=80/0", bus.o_sample, bus.o_sample_valid);
      end
      rst = 1'b0;
      m_req = 0;
      model_reset();
      run_ticks("reset_rest", 2);
   endtask

   task automatic test_sawtooth();
      do_reset();
      set_wave(2'd2);
      set_delta(32'h0100_0000);
      for (int n = 0; n < 256; n++) run_ticks("sawtooth", 1);
   endtask

   task automatic test_square();
      do_reset();
      set_wave(2'd0);
      set_top(8'hFF);
      set_delta(32'h1000_0000);
      run_ticks("square", 32);
   endtask

   task automatic test_top_change();
      do_reset();
      set_wave(2'd0);
      set_delta(32'h1000_0000);
      run_ticks("top_before", 5);
      set_top(8'h3F);
      run_ticks("top_after", 27);
   endtask

   task automatic test_delta_change();
      do_reset();
      set_wave(2'd2);
      set_delta(32'h1000_0000);
      run_ticks("delta_old", 5);
      set_delta(32'h2000_0000);
      run_ticks("delta_new", 20);
   endtask

   task automatic test_rest_start();
      do_reset();
      set_wave(2'd2);
      run_ticks("rest", 4);
      set_delta(32'h0800_0000);
      run_ticks("note_start", 3);
      set_delta(32'h0);
      run_ticks("rest_at_wrap", 36);
   endtask

   task automatic test_noise();
      do_reset();
      set_wave(2'd3);
      set_delta(32'h1000_0000);
      run_ticks("noise", 256);
   endtask

   task automatic test_reset_midflight();
      do_reset();
      set_wave(2'd2);
      set_delta(32'h1000_0000);
      run_ticks("pre_reset", 3);
      @(negedge clk);
      bus.i_tick_stb = 1'b1;
      @(negedge clk);
      bus.i_tick_stb = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         tests++;
         if (bus.o_sample_valid !== 1'b0 || bus.o_sample !== 8'h80) begin
            fails++;
            $display("FAIL midflight_reset cyc=%0d got=%h/%b want=80/0", i, bus.o_sample, bus.o_sample_valid);
         end
         @(negedge clk);
      end
      model_reset();
      run_ticks("post_reset_phase0", 2);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: set_wave(2'($urandom_range(0, 3)));
            1: set_top(8'($urandom_range(0, 255)));
            2: begin
               case ($urandom_range(0, 3))
                  0: set_delta(32'h0);
                  1: set_delta(32'($urandom_range(1, 15)) << 28);
                  default: set_delta($urandom());
               endcase
            end
            default: begin
`ifdef CH_VOLUME_EN
               @(negedge clk);
               m_vol = $urandom_range(0, 15);
               bus.i_volume = 4'(m_vol);
`else
               set_wave(m_wave);
`endif
            end
         endcase
         run_ticks("random_b2b", $urandom_range(1, 8));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.i_tick_stb    = 1'b0;
      bus.i_phase_delta = '0;
      bus.i_top         = 8'hFF;
      bus.i_top_valid   = 1'b0;
      bus.i_waveform    = 2'd2;
      m_wave            = 2'd2;
      m_vol             = 15;
`ifdef CH_VOLUME_EN
      bus.i_volume      = 4'hF;
`endif
      test_reset();
      test_sawtooth();
      test_square();
      test_top_change();
      test_delta_change();
      test_rest_start();
      test_noise();
      test_reset_midflight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
